// File: rtl/sc_leveltimer.sv
// sc_leveltimer -- level timer for the game state machine.
//
// A single-clock IDLE/RUN/DONE controller. In RUN, a down-counter produces
// a one-cycle tick every P clock cycles. Every TICKS_PER_LEVEL ticks the
// level count advances. The run ends when the level reaches LEVEL_MAX.
// The period can be re-programmed while running; a new period only takes
// effect at the next tick reload, so no interval is ever cut short.
//
// Optional feature macro: SC_LEVELTIMER_PAUSE_EN
//   defined   -> PAUSE_InHigh freezes the interval counter and the tick count
//                while in RUN.
//   undefined -> PAUSE_InHigh is accepted but has no effect.
//
// Reset is synchronous and active-high. All outputs are registered.

module sc_leveltimer #(
    parameter int WIDTH           = 32,
    parameter int TICKS_PER_LEVEL = 16,
    parameter int LEVEL_MAX       = 59
) (
    input  logic             SC_LEVELTIMER_CLOCK_50,
    input  logic             SC_LEVELTIMER_RESET_InHigh,
    input  logic             SC_LEVELTIMER_START_InLow,
    input  logic [WIDTH-1:0] SC_LEVELTIMER_PERIOD_IN,
    input  logic             SC_LEVELTIMER_LOAD_InHigh,
    input  logic             SC_LEVELTIMER_PAUSE_InHigh,
    output logic             SC_LEVELTIMER_TICK_OutHigh,
    output logic [7:0]       SC_LEVELTIMER_LEVEL_OUT,
    output logic             SC_LEVELTIMER_RUNNING_OutHigh,
    output logic             SC_LEVELTIMER_DONE_OutHigh
);

    // Width of the per-level tick counter; at least one bit.
    localparam int TCW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    localparam logic [TCW-1:0]   TICK_LAST  = TCW'(TICKS_PER_LEVEL - 1);
    localparam logic [TCW-1:0]   TICK_ONE   = TCW'(1);
    localparam logic [7:0]       LEVEL_LAST = 8'(LEVEL_MAX);
    localparam logic [WIDTH-1:0] PERIOD_MIN = WIDTH'(2);
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Registered state
    state_t           state_q;
    logic [WIDTH-1:0] counter_q;      // cycles remaining until the next tick
    logic [WIDTH-1:0] period_q;       // active tick period P
    logic [WIDTH-1:0] shadow_q;       // pending period, applied at next reload
    logic             shadow_pend_q;  // shadow_q holds an unapplied period
    logic [TCW-1:0]   tick_cnt_q;     // ticks seen in the current level
    logic [7:0]       level_q;
    logic             tick_q;
    logic             running_q;
    logic             done_q;

    // Next-state values
    state_t           state_d;
    logic [WIDTH-1:0] counter_d;
    logic [WIDTH-1:0] period_d;
    logic [WIDTH-1:0] shadow_d;
    logic             shadow_pend_d;
    logic [TCW-1:0]   tick_cnt_d;
    logic [7:0]       level_d;
    logic             tick_d;
    logic             running_d;
    logic             done_d;

    // Helpers
    logic [WIDTH-1:0] period_clamped;  // max(PERIOD_IN, 2)
    logic [WIDTH-1:0] reload_val;      // period used at a tick reload
    logic [7:0]       level_inc;
    logic             pause_active;

`ifdef SC_LEVELTIMER_PAUSE_EN
    assign pause_active = SC_LEVELTIMER_PAUSE_InHigh;
`else
    // Pause input kept on the port for pin compatibility but not used.
    logic unused_pause;
    assign unused_pause = SC_LEVELTIMER_PAUSE_InHigh;
    assign pause_active = 1'b0;
`endif

    // A period below 2 would leave no room for a down-count between ticks.
    assign period_clamped = (SC_LEVELTIMER_PERIOD_IN < PERIOD_MIN) ? PERIOD_MIN
                                                                   : SC_LEVELTIMER_PERIOD_IN;
    assign level_inc      = level_q + 8'd1;

    // Next-state and next-output logic for the IDLE/RUN/DONE controller.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d       = state_q;
        counter_d     = counter_q;
        period_d      = period_q;
        shadow_d      = shadow_q;
        shadow_pend_d = shadow_pend_q;
        tick_cnt_d    = tick_cnt_q;
        level_d       = level_q;
        tick_d        = 1'b0;
        reload_val    = period_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!SC_LEVELTIMER_START_InLow) begin
                    period_d      = period_clamped;
                    counter_d     = period_clamped - CNT_ONE;
                    shadow_pend_d = 1'b0;
                    tick_cnt_d    = '0;
                    level_d       = '0;
                    state_d       = ST_RUN;
                end
            end

            ST_RUN: begin
                // A period update waits in the shadow until the next reload.
                if (SC_LEVELTIMER_LOAD_InHigh) begin
                    shadow_d      = period_clamped;
                    shadow_pend_d = 1'b1;
                end

                // While paused, the counter sits still; a tick due at zero
                // simply fires on the first unpaused edge.
                if (!pause_active) begin
                    if (counter_q == '0) begin
                        // A load arriving on the reload edge wins directly.
                        if (SC_LEVELTIMER_LOAD_InHigh) begin
                            reload_val = period_clamped;
                        end else if (shadow_pend_q) begin
                            reload_val = shadow_q;
                        end else begin
                            reload_val = period_q;
                        end
                        period_d      = reload_val;
                        counter_d     = reload_val - CNT_ONE;
                        shadow_pend_d = 1'b0;
                        tick_d        = 1'b1;

                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_d = '0;
                            level_d    = level_inc;
                            if (level_inc == LEVEL_LAST) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + TICK_ONE;
                        end
                    end else begin
                        counter_d = counter_q - CNT_ONE;
                    end
                end
            end

            ST_DONE: begin
                if (!SC_LEVELTIMER_START_InLow) begin
                    level_d    = '0;
                    tick_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State register and registered outputs; reset overrides every input.
    always_ff @(posedge SC_LEVELTIMER_CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        if (SC_LEVELTIMER_RESET_InHigh) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            period_q      <= '0;
            shadow_q      <= '0;
            shadow_pend_q <= 1'b0;
            tick_cnt_q    <= '0;
            level_q       <= '0;
            tick_q        <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            period_q      <= period_d;
            shadow_q      <= shadow_d;
            shadow_pend_q <= shadow_pend_d;
            tick_cnt_q    <= tick_cnt_d;
            level_q       <= level_d;
            tick_q        <= tick_d;
            running_q     <= running_d;
            done_q        <= done_d;
        end
    end

    assign SC_LEVELTIMER_TICK_OutHigh    = tick_q;
    assign SC_LEVELTIMER_LEVEL_OUT       = level_q;
    assign SC_LEVELTIMER_RUNNING_OutHigh = running_q;
    assign SC_LEVELTIMER_DONE_OutHigh    = done_q;

endmodule

// File: tb/tb_sc_leveltimer.sv
// Self-checking bench for sc_leveltimer.
// Expected tick edges are queued when a run is started; a monitor pops and
// compares them as ticks appear. Small level parameters keep runs short.

module tb_sc_leveltimer;

    localparam int TPL = 4;
    localparam int LM  = 3;
    localparam int W   = 32;

`ifdef SC_LEVELTIMER_PAUSE_EN
    localparam int PAUSE_GAP = 3;  // long pause adds its length to one interval
    localparam int DEFER_GAP = 2;  // pause over a tick edge defers that tick
`else
    localparam int PAUSE_GAP = 0;
    localparam int DEFER_GAP = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start_n;
    logic [W-1:0] period;
    logic         load;
    logic         pause;
    logic         tick;
    logic [7:0]   level;
    logic         running;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;
    int ecount      = 0;  // index of the most recent rising edge
    int exp_q[$];         // expected tick edge indices

    sc_leveltimer #(
        .WIDTH          (W),
        .TICKS_PER_LEVEL(TPL),
        .LEVEL_MAX      (LM)
    ) dut (
        .SC_LEVELTIMER_CLOCK_50       (clk),
        .SC_LEVELTIMER_RESET_InHigh   (rst),
        .SC_LEVELTIMER_START_InLow    (start_n),
        .SC_LEVELTIMER_PERIOD_IN      (period),
        .SC_LEVELTIMER_LOAD_InHigh    (load),
        .SC_LEVELTIMER_PAUSE_InHigh   (pause),
        .SC_LEVELTIMER_TICK_OutHigh   (tick),
        .SC_LEVELTIMER_LEVEL_OUT      (level),
        .SC_LEVELTIMER_RUNNING_OutHigh(running),
        .SC_LEVELTIMER_DONE_OutHigh   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, ecount);
        end
    endtask

    // Tick monitor: every observed tick must match the head of the queue.
    always @(posedge clk) begin
        #1;
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("tick_unexpected_edge", ecount, 0);
            end else begin
                check("tick_edge", ecount, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ticks(input int first, input int p, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + i * p);
    endtask

    // Drive START low for one edge; s is the index of that sampling edge.
    task automatic start_run(input int p, output int s);
        period  = p;
        start_n = 1'b0;
        s       = ecount + 1;
        step(1);
        start_n = 1'b1;
        check("run_flag", running, 1);
        check("run_level", level, 0);
    endtask

    // Wait for the final tick edge, confirm DONE, then return to IDLE.
    task automatic finish_run(input int s_done);
        step(s_done - ecount);
        check("done_flag", done, 1);
        check("done_level", level, LM);
        check("done_running", running, 0);
        step(6);
        check("done_hold_level", level, LM);
        check("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        start_n = 1'b0;
        step(1);
        start_n = 1'b1;
        check("idle_level", level, 0);
        check("idle_done", done, 0);
        check("idle_running", running, 0);
        step(2);
    endtask

    initial begin
        int s;
        rst     = 1'b1;
        start_n = 1'b1;
        period  = '0;
        load    = 1'b0;
        pause   = 1'b0;
        step(2);
        check("rst_tick", tick, 0);
        check("rst_level", level, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        step(2);
        check("idle_stays", running, 0);

        // Period 5: ticks every 5 edges, level steps after 4 ticks.
        start_run(5, s);
        push_ticks(s + 5, 5, TPL * LM);
        step(s + 19 - ecount);
        check("lvl_before", level, 0);
        step(1);
        check("lvl_after", level, 1);
        finish_run(s + 5 * TPL * LM);

        // Periods 0 and 1 clamp to 2.
        start_run(0, s);
        push_ticks(s + 2, 2, TPL * LM);
        finish_run(s + 2 * TPL * LM);
        start_run(1, s);
        push_ticks(s + 2, 2, TPL * LM);
        finish_run(s + 2 * TPL * LM);

        // Period 2: level every 8 edges, DONE after 24; START in RUN ignored.
        start_run(2, s);
        push_ticks(s + 2, 2, TPL * LM);
        step(s + 3 - ecount);
        start_n = 1'b0;
        step(1);
        start_n = 1'b1;
        check("start_in_run", running, 1);
        step(s + 8 - ecount);
        check("p2_lvl1", level, 1);
        step(8);
        check("p2_lvl2", level, 2);
        finish_run(s + 24);

        // LOAD 7 two edges after the first tick: next interval still 5.
        start_run(5, s);
        push_ticks(s + 5, 5, 2);
        push_ticks(s + 17, 7, TPL * LM - 2);
        step(s + 6 - ecount);
        load   = 1'b1;
        period = 7;
        step(1);
        load   = 1'b0;
        period = 0;
        finish_run(s + 17 + 7 * (TPL * LM - 3));

        // LOAD 3 on the reload edge itself: used by that reload.
        start_run(5, s);
        push_ticks(s + 5, 3, TPL * LM);
        step(s + 4 - ecount);
        load   = 1'b1;
        period = 3;
        step(1);
        load   = 1'b0;
        finish_run(s + 5 + 3 * (TPL * LM - 1));

        // Pause for 3 edges mid-interval.
        start_run(5, s);
        push_ticks(s + 5, 5, 1);
        push_ticks(s + 10 + PAUSE_GAP, 5, TPL * LM - 1);
        step(s + 5 - ecount);
        pause = 1'b1;
        step(3);
        pause = 1'b0;
        finish_run(s + 5 * TPL * LM + PAUSE_GAP);

        // Pause over the first tick edge: that tick is deferred.
        start_run(5, s);
        push_ticks(s + 5 + DEFER_GAP, 5, TPL * LM);
        step(s + 4 - ecount);
        pause = 1'b1;
        step(2);
        pause = 1'b0;
        finish_run(s + 5 * TPL * LM + DEFER_GAP);

        // Reset on a would-be tick edge with START held low.
        start_run(5, s);
        step(s + 4 - ecount);
        rst     = 1'b1;
        start_n = 1'b0;
        step(1);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_done", done, 0);
        step(2);
        check("rst_held_running", running, 0);
        rst     = 1'b0;
        start_n = 1'b1;
        step(1);
        check("post_rst_running", running, 0);
        step(10);
        check("post_rst_sb", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sc_leveltimer.md
SC_LEVELTIMER -- requirements
Module: sc_leveltimer

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the period input and the internal cycle counter.
REQ-002 Parameter TICKS_PER_LEVEL, default 16: number of ticks per level increment.
REQ-003 Parameter LEVEL_MAX, default 59: terminal level value.
REQ-004 SC_LEVELTIMER_CLOCK_50  input  1  single clock; all state changes on its rising edge.
REQ-005 SC_LEVELTIMER_RESET_InHigh  input  1  reset; synchronous, active-high.
REQ-006 SC_LEVELTIMER_START_InLow  input  1  start request, active-low, sampled on each edge.
REQ-007 SC_LEVELTIMER_PERIOD_IN  input  WIDTH  tick period in clock cycles.
REQ-008 SC_LEVELTIMER_LOAD_InHigh  input  1  requests a period update from PERIOD_IN.
REQ-009 SC_LEVELTIMER_PAUSE_InHigh  input  1  freezes timing (see Configuration).
REQ-010 SC_LEVELTIMER_TICK_OutHigh  output  1  one-cycle timer tick pulse to the game state machine.
REQ-011 SC_LEVELTIMER_LEVEL_OUT  output  8  current level count.
REQ-012 SC_LEVELTIMER_RUNNING_OutHigh  output  1  high while in RUN.
REQ-013 SC_LEVELTIMER_DONE_OutHigh  output  1  high while in DONE.

Function
REQ-014 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE->RUN: on the edge where START_InLow=0, latch P=max(PERIOD_IN,2) and load counter with P-1.
REQ-016 RUN: counter decrements by 1 per cycle; at the edge where counter=0, set TICK for exactly one cycle and reload counter with P-1.
REQ-017 Tick spacing is exactly P cycles; the first TICK is high in the cycle P edges after the START sample edge.
REQ-018 LOAD_InHigh=1 in RUN latches max(PERIOD_IN,2) into a shadow register; the shadow becomes P at the next reload, never mid-count.
REQ-019 LOAD on the same edge as a reload: the new value is used for that reload.
REQ-020 Each TICK increments tick_cnt; when tick_cnt=TICKS_PER_LEVEL-1, the same tick clears tick_cnt and increments LEVEL_OUT.
REQ-021 When LEVEL_OUT becomes LEVEL_MAX, the FSM enters DONE on that edge; no further TICKs; LEVEL_OUT holds LEVEL_MAX.
REQ-022 DONE->IDLE on START_InLow=0, clearing LEVEL_OUT and tick_cnt; the next START starts a new run.
REQ-023 START_InLow in RUN is ignored; LOAD in IDLE or DONE is ignored.
REQ-024 All counter arithmetic wraps modulo 2^WIDTH; LEVEL_OUT never exceeds LEVEL_MAX.

Reset
REQ-025 With RESET_InHigh=1 at an edge, go to IDLE and set TICK, LEVEL_OUT, RUNNING, DONE, counter, tick_cnt, P and shadow to 0; this overrides all other inputs.
REQ-026 Reset mid-RUN takes effect on the next edge; a TICK pending at that edge is suppressed.

Configuration
REQ-027 With macro SC_LEVELTIMER_PAUSE_EN defined, PAUSE_InHigh=1 in RUN holds counter and tick_cnt and suppresses TICK; counting resumes from the held value.
REQ-028 A pause on a counter=0 edge defers that tick to the first unpaused edge.
REQ-029 Without SC_LEVELTIMER_PAUSE_EN, PAUSE_InHigh is ignored and the port is retained unconnected internally.

Verification
REQ-030 Reset; START low 1 cycle, PERIOD=5 -> TICK high 5 cycles after the start edge, then every 5 cycles; RUNNING=1.
REQ-031 PERIOD=0 or 1 -> TICK every 2 cycles.
REQ-032 TICKS_PER_LEVEL=4, LEVEL_MAX=3, PERIOD=2 -> LEVEL_OUT increments every 8 cycles; DONE=1 after 24 cycles with LEVEL_OUT=3 and no further TICKs; START again -> IDLE with LEVEL_OUT=0.
REQ-033 PERIOD=5 running, LOAD with PERIOD=7 two cycles after a tick -> current interval stays 5, following intervals 7.
REQ-034 PERIOD=5, PAUSE high 3 cycles mid-interval -> interval 8 with macro, 5 without.
REQ-035 RESET high mid-RUN with START held low -> all outputs 0 next cycle; FSM stays in IDLE while reset is high.
